// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   EX-stage integer unit. It decodes the ALU operation and executes it behind
//   a valid/ready handshake. Single-cycle ops register their result one cycle
//   after accept. MUL runs an iterative shift-add loop that retires MUL_BITS
//   multiplier bits per cycle. A registered result is held while the consumer
//   stalls.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands/op presented          in_ready   unit can accept
//   ALUOp      main-decoder class             Funct      {funct7[5], funct3}
//   m_ext      funct7[0], M-extension select
//   a, b       operands (b may be an immediate)
//   out_valid  result valid                   out_ready  consumer accepts
//   result     registered result              Operation  registered opcode
//   zero       result == 0, registered with result
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN     = 64,
  parameter bit MUL_EN   = 1'b1,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [3:0]      Funct,
  input  logic            m_ext,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      Operation,
  output logic            zero
);

  localparam int SHW   = $clog2(XLEN);
  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011,
    OP_SRL  = 4'b0100, OP_SRA  = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
    OP_SLL  = 4'b1000, OP_SLTU = 4'b1001, OP_MUL = 4'b1010
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state, state_next;
  op_e             op_dec;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] mcand, mplier, acc, acc_step;
  logic [CW-1:0]   count;
  logic            accept;

  assign shamt    = b[SHW-1:0];
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Operation decode.
  // NOTE: the default at the top assigns op_dec on every path, so no latch can be inferred.
  always_comb begin
    op_dec = OP_ADD;
    case (ALUOp)
      2'b00: begin
        if (Funct[2:0] == 3'b001)      op_dec = OP_SLL;
        else if (Funct[2:0] == 3'b101) op_dec = Funct[3] ? OP_SRA : OP_SRL;
      end
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        if (MUL_EN && m_ext && Funct[2:0] == 3'b000) begin
          op_dec = OP_MUL;
        end else begin
          case (Funct)
            4'b0000: op_dec = OP_ADD;
            4'b1000: op_dec = OP_SUB;
            4'b0111: op_dec = OP_AND;
            4'b0110: op_dec = OP_OR;
            4'b0100: op_dec = OP_XOR;
            4'b0001: op_dec = OP_SLL;
            4'b0101: op_dec = OP_SRL;
            4'b1101: op_dec = OP_SRA;
            4'b0010: op_dec = OP_SLT;
            4'b0011: op_dec = OP_SLTU;
            default: op_dec = OP_ADD;
          endcase
        end
      end
      default: op_dec = OP_ADD;
    endcase
  end

  // Single-cycle datapath. MUL never reaches this path.
  always_comb begin
    alu_res = a + b;
    case (op_dec)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: alu_res = a + b;
    endcase
  end

  // One multiplier step: add the partial products of the low MUL_BITS multiplier bits.
  // NOTE: blocking assignments chain the partial sums inside combinational logic.
  always_comb begin
    acc_step = acc;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) acc_step = acc_step + (mcand << i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && op_dec == OP_MUL) state_next = S_MUL;
      S_MUL:   if (count == CW'(1))            state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result, handshake and multiplier registers.
  // NOTE: the multiplier work registers get a reset too. A reset during MUL then leaves nothing stale behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      Operation <= OP_ADD;
      zero      <= 1'b1;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      count  <= count - CW'(1);
      if (count == CW'(1)) begin
        result    <= acc_step;
        Operation <= OP_MUL;
        zero      <= (acc_step == '0);
        out_valid <= 1'b1;
      end
    end else if (accept) begin
      if (op_dec == OP_MUL) begin
        mcand     <= a;
        mplier    <= b;
        acc       <= '0;
        count     <= CW'(STEPS);
        out_valid <= 1'b0;  // an accept implies any previous result is consumed
      end else begin
        result    <= alu_res;
        Operation <= op_dec;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Three instances share the operand buses:
//     dut  - XLEN=64, MUL_EN=1, MUL_BITS=1
//     dut4 - XLEN=64, MUL_EN=1, MUL_BITS=4
//     dutn - XLEN=64, MUL_EN=0
//   Each instance has its own in_valid and out_ready. A directed sequence is
//   followed by a randomized stream. The stream is compared against a
//   cycle-level reference model of the handshake and arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_SRL = 4'b0100, OP_SRA = 4'b0101,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLL = 4'b1000,
                         OP_SLTU = 4'b1001, OP_MUL = 4'b1010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic        m_ext;
  logic [63:0] a, b;

  logic        in_valid, out_ready, in_ready, out_valid, zero;
  logic [63:0] result;
  logic [3:0]  Operation;

  logic        in_valid4, out_ready4, in_ready4, out_valid4, zero4;
  logic [63:0] result4;
  logic [3:0]  Operation4;

  logic        in_validn, out_readyn, in_readyn, out_validn, zeron;
  logic [63:0] resultn;
  logic [3:0]  Operationn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(64), .MUL_EN(1'b1), .MUL_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .m_ext(m_ext), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .Operation(Operation), .zero(zero));

  alu_exec_unit #(.XLEN(64), .MUL_EN(1'b1), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .ALUOp(ALUOp), .Funct(Funct), .m_ext(m_ext), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .Operation(Operation4), .zero(zero4));

  alu_exec_unit #(.XLEN(64), .MUL_EN(1'b0), .MUL_BITS(1)) dutn (
    .clk(clk), .reset_n(reset_n), .in_valid(in_validn), .in_ready(in_readyn),
    .ALUOp(ALUOp), .Funct(Funct), .m_ext(m_ext), .a(a), .b(b),
    .out_valid(out_validn), .out_ready(out_readyn), .result(resultn),
    .Operation(Operationn), .zero(zeron));

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_decode(input logic [1:0] cls, input logic [3:0] f,
                                            input logic m, input bit mul_en);
    logic [2:0] f3;
    f3 = f[2:0];
    if (cls == 2'b01) return OP_SUB;
    if (cls == 2'b00) begin
      if (f3 == 3'b001) return OP_SLL;
      if (f3 == 3'b101) return f[3] ? OP_SRA : OP_SRL;
      return OP_ADD;
    end
    if (cls == 2'b10) begin
      if (m && f3 == 3'b000 && mul_en) return OP_MUL;
      case (f)
        4'b1000: return OP_SUB;
        4'b0111: return OP_AND;
        4'b0110: return OP_OR;
        4'b0100: return OP_XOR;
        4'b0001: return OP_SLL;
        4'b0101: return OP_SRL;
        4'b1101: return OP_SRA;
        4'b0010: return OP_SLT;
        4'b0011: return OP_SLTU;
        default: return OP_ADD;
      endcase
    end
    return OP_ADD;
  endfunction

  function automatic logic [63:0] ref_exec(input logic [3:0] op, input logic [63:0] x,
                                           input logic [63:0] y);
    int sh;
    sh = int'(y % 64);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SUB:  return x - y;
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $signed(x) >>> sh;
      OP_SLT:  return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      OP_SLTU: return (x < y) ? 64'd1 : 64'd0;
      OP_MUL:  return x * y;
      default: return x + y;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op to one instance (0 main, 1 MUL_BITS=4, 2 MUL_EN=0; other = none).
  task automatic drive(input logic [1:0] cls, input logic [3:0] f, input logic m,
                       input logic [63:0] x, input logic [63:0] y, input int which);
    ALUOp = cls; Funct = f; m_ext = m; a = x; b = y;
    in_valid  = (which == 0);
    in_valid4 = (which == 1);
    in_validn = (which == 2);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   lat;
    logic saw;
    logic m_ovalid, m_ready;
    int   mul_left;
    logic [63:0] m_res, pend, ra, rb;
    logic [3:0]  m_op, op;
    logic [1:0]  cls;
    logic [3:0]  f;
    logic        m;

    reset_n = 1'b0;
    ALUOp = 2'b00; Funct = 4'b0000; m_ext = 1'b0; a = '0; b = '0;
    in_valid = 1'b0; in_valid4 = 1'b0; in_validn = 1'b0;
    out_ready = 1'b1; out_ready4 = 1'b1; out_readyn = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    result,         64'd0);
    check("rst_operation", 64'(Operation), 64'(OP_ADD));
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    step();
    reset_n = 1'b1;
    step();

    // Back-to-back stream with out_ready=1.
    drive(2'b10, 4'b0000, 1'b0, 64'd5, 64'd7, 0);
    check("stream_add_in_ready", 64'(in_ready), 64'd1);
    step();
    check("stream_add_res", result, 64'd12);
    check("stream_add_op",  64'(Operation), 64'(OP_ADD));
    drive(2'b10, 4'b1000, 1'b0, 64'd5, 64'd7, 0);
    step();
    check("stream_sub_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("stream_sub_op",  64'(Operation), 64'(OP_SUB));
    check("stream_sub_valid", 64'(out_valid), 64'd1);
    drive(2'b10, 4'b0100, 1'b0, 64'hF0, 64'hFF, 0);
    step();
    check("stream_xor_res", result, 64'h0F);
    check("stream_xor_op",  64'(Operation), 64'(OP_XOR));
    drive(2'b10, 4'b0011, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    step();
    check("stream_sltu_res", result, 64'd1);
    check("stream_sltu_op",  64'(Operation), 64'(OP_SLTU));

    // Shifts, undefined R-type, reserved class.
    drive(2'b00, 4'b0001, 1'b0, 64'd1, 64'h43, 0);
    step();
    check("slli_res", result, 64'd8);
    check("slli_op",  64'(Operation), 64'(OP_SLL));
    drive(2'b10, 4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 0);
    step();
    check("sra_res", result, 64'hF800_0000_0000_0000);
    check("sra_op",  64'(Operation), 64'(OP_SRA));
    drive(2'b10, 4'b1111, 1'b0, 64'd1, 64'd1, 0);
    step();
    check("undef_op",  64'(Operation), 64'(OP_ADD));
    check("undef_res", result, 64'd2);
    drive(2'b11, 4'b1000, 1'b0, 64'd10, 64'd3, 0);
    step();
    check("aluop11_res", result, 64'd13);
    check("aluop11_op",  64'(Operation), 64'(OP_ADD));
    drive(2'b01, 4'b0000, 1'b0, 64'd9, 64'd9, 0);
    step();
    check("branch_sub_zero", 64'(zero), 64'd1);
    check("branch_sub_op",   64'(Operation), 64'(OP_SUB));
    drive(2'b00, 4'b0000, 1'b0, 64'd0, 64'd0, 3);
    step();
    check("release_out_valid", 64'(out_valid), 64'd0);

    // MUL, MUL_BITS=1.
    drive(2'b10, 4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
    step();
    drive(2'b10, 4'b0000, 1'b0, 64'd77, 64'd88, 3);  // ignored while busy
    lat = 0; saw = 1'b0;
    do begin
      if (in_ready) saw = 1'b1;
      step();
      lat++;
    end while (!out_valid && lat < 200);
    check("mul1_latency", 64'(lat), 64'd64);
    check("mul1_in_ready_low", 64'(saw), 64'd0);
    check("mul1_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul1_op",  64'(Operation), 64'(OP_MUL));
    check("mul1_zero", 64'(zero), 64'd0);
    step();

    // MUL, MUL_BITS=4.
    drive(2'b10, 4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1);
    step();
    drive(2'b00, 4'b0000, 1'b0, 64'd0, 64'd0, 3);
    lat = 0; saw = 1'b0;
    do begin
      if (in_ready4) saw = 1'b1;
      step();
      lat++;
    end while (!out_valid4 && lat < 200);
    check("mul4_latency", 64'(lat), 64'd16);
    check("mul4_in_ready_low", 64'(saw), 64'd0);
    check("mul4_res", result4, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul4_op",  64'(Operation4), 64'(OP_MUL));

    // MUL_EN=0: the MUL encoding decodes as ADD with latency 1.
    drive(2'b10, 4'b0000, 1'b1, 64'd5, 64'd7, 2);
    step();
    drive(2'b00, 4'b0000, 1'b0, 64'd0, 64'd0, 3);
    check("nomul_valid", 64'(out_validn), 64'd1);
    check("nomul_res",   resultn, 64'd12);
    check("nomul_op",    64'(Operationn), 64'(OP_ADD));
    step();

    // Backpressure hold, then a consume and accept in the same cycle.
    out_ready = 1'b0;
    drive(2'b10, 4'b0000, 1'b0, 64'd2, 64'd3, 0);
    step();
    drive(2'b10, 4'b1000, 1'b0, 64'd100, 64'd1, 3);
    for (int i = 0; i < 5; i++) begin
      check("hold_res",      result, 64'd5);
      check("hold_valid",    64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    drive(2'b10, 4'b0111, 1'b0, 64'd6, 64'd3, 0);
    check("consume_in_ready", 64'(in_ready), 64'd1);
    step();
    check("consume_and_res",   result, 64'd2);
    check("consume_and_valid", 64'(out_valid), 64'd1);
    check("consume_and_op",    64'(Operation), 64'(OP_AND));

    // Asynchronous reset mid-cycle while a result is held.
    out_ready = 1'b0;
    drive(2'b00, 4'b0000, 1'b0, 64'd0, 64'd0, 3);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid",    64'(out_valid), 64'd0);
    check("async_rst_res",      result, 64'd0);
    check("async_rst_zero",     64'(zero), 64'd1);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;

    // Reset during MUL aborts with no output pulse.
    drive(2'b10, 4'b0000, 1'b1, 64'd11, 64'd13, 0);
    step();
    drive(2'b00, 4'b0000, 1'b0, 64'd0, 64'd0, 3);
    repeat (10) step();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) saw = 1'b1;
      step();
    end
    check("mul_abort_no_valid", 64'(saw), 64'd0);
    check("mul_abort_in_ready", 64'(in_ready), 64'd1);

    // Randomized stream against the reference model.
    m_ovalid = 1'b0; mul_left = 0; m_res = '0; m_op = OP_ADD; pend = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 19) == 0) begin
          cls = 2'b10; f = {1'($urandom), 3'b000}; m = 1'b1;
        end else begin
          cls = 2'($urandom); f = 4'($urandom); m = 1'b0;
        end
        drive(cls, f, m, ra, rb, 0);
      end else begin
        drive(2'($urandom), 4'($urandom), 1'b0, ra, rb, 3);
      end

      m_ready = (mul_left == 0) && (!m_ovalid || out_ready);
      check("rnd_in_ready",  64'(in_ready), 64'(m_ready));
      check("rnd_out_valid", 64'(out_valid), 64'(m_ovalid));
      if (m_ovalid) begin
        check("rnd_result", result, m_res);
        check("rnd_op",     64'(Operation), 64'(m_op));
        check("rnd_zero",   64'(zero), 64'(m_res == 64'd0));
      end

      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          m_ovalid = 1'b1; m_op = OP_MUL; m_res = pend;
        end
      end else if (in_valid && m_ready) begin
        op = ref_decode(ALUOp, Funct, m_ext, 1'b1);
        if (op == OP_MUL) begin
          mul_left = 64; m_ovalid = 1'b0; pend = ref_exec(OP_MUL, a, b);
        end else begin
          m_ovalid = 1'b1; m_op = op; m_res = ref_exec(op, a, b);
        end
      end else if (out_ready) begin
        m_ovalid = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
